// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared 7-segment constants (active-low gfedcba) and the
//               fetch state encoding for display read blocks.
// Revision    : 1.0
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    // Entry i is the active-low {g,f,e,d,c,b,a} pattern for hex digit i.
    localparam logic [15:0][6:0] c_HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_READ = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational 4-bit to active-low 7-segment decoder.
// Revision    : 1.0
// ============================================================================
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = c_HEX_SEG[nibble_i];

endmodule
`default_nettype wire

// File: rtl/seg_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_reader
// Description : Fetches one memory word per digit over a request/grant port
//               and drives a multiplexed common-anode 7-segment display.
// Revision    : 1.0
// ============================================================================
module seg_scan_reader
    import seg7_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 6,
    parameter int DIGITS      = 4,
    parameter int BASE_ADDR   = 0,
    parameter int REFRESH_DIV = 50000
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rd_req,
    input  logic              rd_gnt,
    output logic [DEPTH-1:0]  addr,
    input  logic [WIDTH-1:0]  mem_data,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output logic              overrun
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(DIGITS);

    logic [CW-1:0]              cnt_q, cnt_d;
    logic [DW-1:0]              digit_q, digit_d;
    logic [DW-1:0]              target_q, target_d;
    fetch_state_e               state_q, state_d;
    logic                       start_q, start_d;
    logic [DEPTH-1:0]           addr_q, addr_d;
    logic [DIGITS-1:0][WIDTH-1:0] buf_q;
    logic [DIGITS-1:0]          an_q;
    logic [6:0]                 seg_q;
    logic                       dp_q;
    logic                       overrun_q;

    logic                       w_slot;
    logic                       w_wr_en;
    logic [DW-1:0]              w_next_tgt;
    logic [WIDTH-1:0]           w_word;
    logic [6:0]                 w_seg;

    assign w_slot = en && (cnt_q == CW'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        if (en) begin
            if (w_slot) begin
                cnt_d   = '0;
                digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Target is the digit after the one about to be lit, so it loads ahead of use.
    assign w_next_tgt = (digit_d == DW'(DIGITS - 1)) ? '0 : digit_d + 1'b1;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        addr_d   = addr_q;
        start_d  = start_q;
        w_wr_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && (start_q || w_slot)) begin
                    state_d  = S_REQ;
                    start_d  = 1'b0;
                    target_d = w_next_tgt;
                    addr_d   = DEPTH'(BASE_ADDR + int'(w_next_tgt));
                end
            end
            S_REQ: begin
                if (rd_gnt) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                w_wr_en = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_word = buf_q[digit_q];

    generate
        if (WIDTH > 5) begin : g_unused_mid
            logic w_unused_mid;
            assign w_unused_mid = ^w_word[WIDTH-2:4];
        end
    endgenerate

    hex_to_7seg u_dec (
        .nibble_i (w_word[3:0]),
        .seg_o    (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            digit_q   <= '0;
            target_q  <= '0;
            state_q   <= S_IDLE;
            start_q   <= 1'b1;
            addr_q    <= '0;
            buf_q     <= '0;
            an_q      <= '1;
            seg_q     <= c_SEG_BLANK;
            dp_q      <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            target_q  <= target_d;
            state_q   <= state_d;
            start_q   <= start_d;
            addr_q    <= addr_d;
            if (w_wr_en) begin
                buf_q[target_q] <= mem_data;
            end
            an_q      <= en ? ~(DIGITS'(1) << digit_q) : '1;
            seg_q     <= en ? w_seg : c_SEG_BLANK;
            dp_q      <= en ? ~w_word[WIDTH-1] : 1'b1;
            overrun_q <= w_slot && (state_q != S_IDLE);
        end
    end

    assign rd_req  = (state_q != S_IDLE);
    assign addr    = addr_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: doc/seg_scan_reader.md
# seg_scan_reader

Read-side companion to the single-port display memory: fetches one word per digit from memory over a request/grant port, buffers it, and drives a time-multiplexed, common-anode 7-segment display. Sits between the memory (shared with the write path through a top-level arbiter) and the board display pins. Low nibble of each word is shown as a hex digit; the MSB drives the decimal point.

## Interface
- WIDTH, 8: memory word width; must be ≥ 5.
- DEPTH, 6: memory address width.
- DIGITS, 4: number of display digits, 2..8.
- BASE_ADDR, 0: memory address of digit 0; digit i reads BASE_ADDR+i, modulo 2**DEPTH.
- REFRESH_DIV, 50000: clk cycles each digit is lit; must be ≥ 4.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  display enable; 0 blanks the display and freezes the scan.
- rd_req  out  1  memory read request.
- rd_gnt  in  1  grant from arbiter; memory port owned by this block while rd_req && rd_gnt.
- addr  out  DEPTH  memory address; valid whenever rd_req=1.
- mem_data  in  WIDTH  asynchronous memory read data for addr.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  digit anodes, active-low, one-hot-low when lit.
- overrun  out  1  one-cycle pulse: slot boundary reached while a fetch is still pending.

## Operation
- Reset (rst=0 at an edge): refresh counter=0, digit index=0, fetch FSM=IDLE, display buffer all 0, rd_req=0, addr=0, an=all 1, seg=7'b1111111, dp=1, overrun=0.
- Refresh counter counts 0..REFRESH_DIV-1 while en=1; at terminal count it wraps to 0 and digit index advances, DIGITS-1 wraps to 0 (slot boundary).
- Display: with en=1, an bit [digit] = 0, others 1; seg = hex decode of buf[digit][3:0]; dp = ~buf[digit][WIDTH-1]. With en=0: an all 1, seg/dp all 1, counter and digit index hold.
- Fetch target is always (digit+1) mod DIGITS, so the next digit is loaded before it is lit.
- Fetch FSM states: IDLE, REQ, READ.
  - IDLE → REQ: on the first cycle after reset release with en=1, and on every slot boundary with en=1; latches target index.
  - REQ: rd_req=1, addr=BASE_ADDR+target; on sampling rd_gnt=1 → READ; otherwise stays.
  - READ: rd_req=1, addr unchanged; at end of cycle buf[target] ← mem_data; → IDLE, rd_req=0.
- Slot boundary while FSM ≠ IDLE: overrun pulses; pending fetch continues unchanged; no new request queued.
- en falling mid-fetch: in-flight fetch completes normally; no new fetch starts until en=1.
- rd_gnt deasserted while in READ: ignored, word still captured (arbiter must hold grant for one cycle after it is issued).
- Decode (active-low, gfedcba): 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; full hex table in package.

## Timing
- rd_req rises one cycle after the triggering slot boundary (or reset release).
- Minimum fetch: 2 cycles with rd_req high (REQ with rd_gnt=1, then READ); buffer updated at end of READ.
- addr is registered; stable ≥ 1 full cycle before mem_data is sampled.
- seg/an/dp are registered: change one cycle after the digit index changes.
- Buffer write and display of same entry never coincide (target ≠ digit for DIGITS ≥ 2).

## Structure
- Shared package seg7_pkg: 7-bit hex-to-segment constant table, blank constant 7'b1111111, fetch state enum.
- Sub-module hex_to_7seg: combinational 4-bit → 7-bit active-low decoder, reused by other display blocks.
- Top holds refresh counter, digit index, fetch FSM, DIGITS×WIDTH buffer, output registers.

## Test plan
- Reset: rst=0 for 3 cycles, en=1 → an=4'b1111, seg=7'b1111111, rd_req=0; after release rd_req=1 next cycle with addr=BASE_ADDR+1.
- Full scan: memory[0..3]=8'h01,8'h0A,8'h8F,8'h08, REFRESH_DIV=4, rd_gnt tied 1 → after 4 slots digit 2 shows seg=0001110 dp=0, digit 1 shows 0001000, an rotates 1110→1101→1011→0111→1110.
- Grant stall: hold rd_gnt=0 for 6 cycles with REFRESH_DIV=4 → overrun pulses once, rd_req stays high, addr stable; buffer loads 2 cycles after rd_gnt rises.
- Wrap addressing: DEPTH=3, BASE_ADDR=6, DIGITS=4 → addr sequence 7,0,1,6 over successive slots.
- Enable: drop en mid-REQ → display blanks next cycle, fetch completes, no further rd_req; raise en → scan resumes from same digit and counter value.
- Reset mid-fetch: rst=0 during READ → buffer not written, all outputs at reset values next cycle.
